// File: rtl/dot_requant_packer_if.sv
// dot_requant_packer_if: partial-sum input stream and packed-vector output stream of dot_requant_packer.
interface dot_requant_packer_if #(
  parameter int RES_WIDTH = 14,
  parameter int OUT_WIDTH = 4,
  parameter int VEC_SIZE  = 64
);
  localparam int VEC_WIDTH = OUT_WIDTH * VEC_SIZE;
  localparam int CNT_WIDTH = $clog2(VEC_SIZE) + 1;
  logic                        i_valid;
  logic                        o_ready;
  logic signed [RES_WIDTH-1:0] i_product;
  logic                        i_last;
  logic [4:0]                  i_shift;
  logic                        o_valid;
  logic                        i_ready;
  logic [VEC_WIDTH-1:0]        o_vec;
  logic [CNT_WIDTH-1:0]        o_sat_cnt;
  modport master (
    output i_valid, i_product, i_last, i_shift, i_ready,
    input  o_ready, o_valid, o_vec, o_sat_cnt
  );
  modport slave (
    input  i_valid, i_product, i_last, i_shift, i_ready,
    output o_ready, o_valid, o_vec, o_sat_cnt
  );
endinterface

// File: rtl/dot_requant_packer.sv
// dot_requant_packer: accumulates partial sums over K-tiles, requantizes to signed 4-bit and packs VEC_SIZE lanes.
// Define REQUANT_ROUND_EN for round-half-up before the shift; otherwise the shift truncates (floor).
module dot_requant_packer #(
  parameter int RES_WIDTH = 14,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 4,
  parameter int VEC_SIZE  = 64,
  parameter int VEC_WIDTH = OUT_WIDTH * VEC_SIZE
) (
  input logic i_clk,
  input logic i_rst,
  dot_requant_packer_if.slave bus
);
  localparam int CW = $clog2(VEC_SIZE) + 1;
  localparam int LW = VEC_SIZE > 1 ? $clog2(VEC_SIZE) : 1;
  typedef enum logic {FILL, FULL} state_t;
  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic [LW-1:0]               lane_q, lane_d;
  logic [VEC_WIDTH-1:0]        vec_q, vec_d;
  logic [CW-1:0]               sat_q, sat_d;
  logic signed [ACC_WIDTH:0]   q;
  logic [OUT_WIDTH-1:0]        res;
  logic                        accept, done, drain, wrap, clip_hi, clip_lo;
  assign bus.o_valid   = state_q == FULL;
  assign bus.o_ready   = state_q == FILL || bus.i_ready;
  assign bus.o_vec     = vec_q;
  assign bus.o_sat_cnt = sat_q;
  always_comb sum = acc_q + ACC_WIDTH'(bus.i_product);
`ifdef REQUANT_ROUND_EN
  logic signed [ACC_WIDTH:0] rnd;
  // One extra bit so adding the half-LSB cannot overflow the accumulator range.
  always_comb rnd = bus.i_shift == 5'd0 ? '0 : (ACC_WIDTH+1)'(1) << (bus.i_shift - 5'd1);
  always_comb q = ($signed({sum[ACC_WIDTH-1], sum}) + rnd) >>> bus.i_shift;
`else
  always_comb q = $signed({sum[ACC_WIDTH-1], sum}) >>> bus.i_shift;
`endif
  always_comb begin
    clip_hi = !q[ACC_WIDTH] && (|q[ACC_WIDTH-1:OUT_WIDTH-1]);
    clip_lo = q[ACC_WIDTH] && !(&q[ACC_WIDTH-1:OUT_WIDTH-1]);
    res     = clip_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
              clip_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : q[OUT_WIDTH-1:0];
  end
  always_comb begin
    accept  = bus.i_valid && bus.o_ready;
    done    = accept && bus.i_last;
    drain   = state_q == FULL && bus.i_ready;
    wrap    = lane_q == LW'(VEC_SIZE - 1);
    acc_d   = accept ? (bus.i_last ? '0 : sum) : acc_q;
    lane_d  = done ? (wrap ? '0 : lane_q + 1'b1) : lane_q;
    // Draining clears the buffer so a same-cycle lane-0 write starts a clean vector.
    vec_d   = drain ? '0 : vec_q;
    if (done) vec_d[lane_q*OUT_WIDTH +: OUT_WIDTH] = res;
    sat_d   = (drain ? '0 : sat_q) + CW'(done && (clip_hi || clip_lo));
    state_d = done && wrap ? FULL : drain ? FILL : state_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      lane_q  <= '0;
      vec_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lane_q  <= lane_d;
      vec_q   <= vec_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: doc/dot_requant_packer.md
# dot_requant_packer

Downstream stage of the dot-product unit. Accepts a stream of signed dot-product partial sums, accumulates them across K-tiles, and requantizes each finished sum with an arithmetic right shift and saturation to a signed 4-bit value. It packs VEC_SIZE results into one 256-bit flattened vector so the result can be fed back as an `i_a`/`i_b` operand of the next dot-product pass.

## Interface
- RES_WIDTH, 14: width of the incoming signed partial sum (4-bit operands, 64 lanes).
- ACC_WIDTH, 24: width of the signed accumulator.
- OUT_WIDTH, 4: width of each requantized signed result.
- VEC_SIZE, 64: results per packed output vector.
- VEC_WIDTH, OUT_WIDTH*VEC_SIZE (256): packed output width.

Ports (name, direction, width, meaning):
- i_clk, input, 1: clock. All state changes on the rising edge.
- i_rst, input, 1: reset, synchronous and active-high.
- i_valid, input, 1: upstream partial sum valid.
- o_ready, output, 1: block can accept a partial sum.
- i_product, input, RES_WIDTH: signed partial sum.
- i_last, input, 1: this beat is the final K-tile of the current output element.
- i_shift, input, 5: requant right-shift amount, 0..ACC_WIDTH-1. Sampled only on an accepted beat with i_last=1.
- o_valid, output, 1: packed vector valid.
- i_ready, input, 1: downstream accepts the packed vector.
- o_vec, output, VEC_WIDTH: packed results. Lane n is at [n*OUT_WIDTH +: OUT_WIDTH].
- o_sat_cnt, output, $clog2(VEC_SIZE)+1: number of saturated lanes in o_vec.

## Operation
- Accept condition: i_valid && o_ready, with o_ready = !o_valid || i_ready.
- Sum: sum = acc + sign_extend(i_product) at ACC_WIDTH. The accumulator is not saturated. The host keeps the tile count within ACC_WIDTH.
- Accepted beat with i_last=0: acc <= sum.
- Accepted beat with i_last=1:
  - q = sum >>> i_shift (arithmetic shift).
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], which is [-8, 7].
  - Write the result into lane[lane_idx].
  - Increment o_sat_cnt's internal counter if clipping occurred.
  - acc <= 0.
  - lane_idx <= lane_idx+1, wrapping to 0 after VEC_SIZE-1.
- State machine, two states:
  - FILL (o_valid=0): accept beats. An i_last beat into lane VEC_SIZE-1 moves to FULL.
  - FULL (o_valid=1): o_vec and o_sat_cnt are held stable until i_valid-independent i_ready=1. On i_ready=1, return to FILL unless the same-cycle accepted beat completes lane VEC_SIZE-1 of the next vector, which is only possible when VEC_SIZE=1.
- Simultaneous drain and accept (FULL, i_ready=1, i_valid=1):
  - The beat is accepted.
  - An i_last beat writes lane 0 of the new vector.
  - All other lanes and the saturation counter restart from zero. Lanes are not written stale: the vector buffer clears on drain, and the new lane 0 value overrides.
- Lanes not yet written in a vector read as 0. In normal operation o_valid only asserts with all lanes written.

## Timing
- Reset values: o_valid=0, o_vec=0, o_sat_cnt=0, acc=0, lane_idx=0, state FILL. o_ready=1 one cycle after reset deasserts.
- Reset mid-operation discards the partial accumulator, all packed lanes and any pending vector. i_rst has priority over every other event.
- Accumulate latency: the beat accepted at cycle t is reflected in acc at t+1.
- Output latency: an i_last beat into the final lane, accepted at t, gives o_valid=1 at t+1.
- Throughput: one partial sum per cycle. No bubble between vectors if i_ready=1 when o_valid rises.
- Backpressure: while FULL and i_ready=0, o_ready=0. i_product, i_last and i_shift are ignored.

## Configuration
- REQUANT_ROUND_EN defined: round half up before the shift.
  - q = (sum + (1 << (i_shift-1))) >>> i_shift for i_shift>0, computed at ACC_WIDTH+1 bits so the addition cannot overflow.
  - q = sum when i_shift=0.
- REQUANT_ROUND_EN undefined: truncating arithmetic shift (floor). The rounding adder is not synthesized.

## Test plan
- Single-tile values: VEC_SIZE=4, i_shift=0, products 3, -2, 7, -8 each with i_last=1 -> o_valid one cycle after the 4th beat, o_vec=16'h87E3, o_sat_cnt=0.
- Multi-tile and saturation: lane 0 gets tiles 5,5 then i_last, so sum=10; lane 1 gets -9 -> lanes 7 and -8, o_sat_cnt=2.
- Rounding with sum=6, i_shift=2:
  - Lane value 2 with REQUANT_ROUND_EN.
  - Lane value 1 without it.
  - With sum=-6: -1 with the macro, -2 without.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_ready=0, o_vec stable. Extra i_valid beats must not change acc. Release gives one-cycle handshake, then FILL.
- Back-to-back: i_ready=1 and continuous i_valid over 2 vectors -> second vector's o_valid exactly VEC_SIZE cycles after the first. Lane 0 of vector 2 is correct despite the same-cycle drain.
- Reset mid-vector: 2 lanes written plus a partial acc=13, then i_rst for 1 cycle. A fresh single beat of 1 with i_last lands in lane 0 as 1, and the first vector is all zeros except filled lanes.
